// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller and its BCD converter.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_VALUE  = 9999;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_t;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                   input logic             in_bit);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return {res[BCD_W-2:0], in_bit};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock, BIN_W shifts per value.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd,
  output conv_state_t      o_state
);

  // Handshake: i_start is taken only while o_busy is low (no queueing); o_done is high
  // for the single COMMIT cycle in which o_bcd holds the finished result.
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] scratch;
  logic [CNT_W-1:0] shift_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= CONV_IDLE;
      bin_sr    <= '0;
      scratch   <= '0;
      shift_cnt <= '0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (i_start) begin
            bin_sr    <= i_bin;
            scratch   <= '0;
            shift_cnt <= '0;
            state     <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          scratch   <= dabble_step(scratch, bin_sr[BIN_W-1]);
          bin_sr    <= {bin_sr[BIN_W-2:0], 1'b0};
          shift_cnt <= shift_cnt + 1'b1;
          if (shift_cnt == CNT_W'(BIN_W - 1)) state <= CONV_COMMIT;
        end
        CONV_COMMIT: state <= CONV_IDLE;
        default:     state <= CONV_IDLE;
      endcase
    end
  end

  assign o_busy  = (state != CONV_IDLE);
  assign o_done  = (state == CONV_COMMIT);
  assign o_bcd   = scratch;
  assign o_state = state;

endmodule

// File: rtl/fnd_scan_controller.sv
// Converts a clamped binary value to BCD and scans the four digits onto a
// common-anode FND with per-digit ghost blanking and optional leading-zero suppression.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_load,
  input  logic             i_blankLeadingZero,
  output logic [1:0]       o_digitSelect,
  output logic [3:0]       o_value,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_overflow
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  generate
    if (BLANK_CYCLES <= 0 || BLANK_CYCLES >= DIV) begin : g_bad_blank
      $error("BLANK_CYCLES must satisfy 0 < BLANK_CYCLES < CLK_HZ/SCAN_HZ");
    end
  endgenerate

  conv_state_t             conv_state;
  logic                    conv_busy;
  logic                    conv_done;
  logic [BCD_W-1:0]        conv_bcd;
  logic                    over;
  logic [BIN_W-1:0]        clamped;
  logic                    start;

  assign over    = (i_value > BIN_W'(MAX_VALUE));
  assign clamped = over ? BIN_W'(MAX_VALUE) : i_value;
  assign start   = i_load && (conv_state == CONV_IDLE);

  bin2bcd_seq u_bin2bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (start),
    .i_bin   (clamped),
    .o_busy  (conv_busy),
    .o_done  (conv_done),
    .o_bcd   (conv_bcd),
    .o_state (conv_state)
  );

  // Display digits only change on COMMIT, so a scan never sees a half-converted value.
  logic [NUM_DIGITS-1:0][3:0] disp;
  logic                       overflow_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      disp       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (start)     overflow_q <= over;
      if (conv_done) disp       <= conv_bcd;
    end
  end

  logic [TICK_W-1:0]  tick;
  logic [BLANK_W-1:0] blank;
  logic [1:0]         sel;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick  <= '0;
      blank <= BLANK_W'(BLANK_CYCLES);
      sel   <= '0;
    end else if (tick == TICK_W'(DIV - 1)) begin
      tick  <= '0;
      sel   <= sel + 2'd1;
      blank <= BLANK_W'(BLANK_CYCLES);
    end else begin
      tick <= tick + 1'b1;
      if (blank != '0) blank <= blank - 1'b1;
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  logic all_zero;
  logic suppressed;

  always_comb begin
    all_zero   = 1'b1;
    suppressed = 1'b0;
    for (int d = NUM_DIGITS - 1; d > 0; d--) begin
      all_zero = all_zero && (disp[d] == 4'd0);
      if (sel == 2'(d)) suppressed = all_zero;
    end
  end

  assign o_digitSelect = sel;
  assign o_value       = disp[sel];
  assign o_en          = (blank == '0) && !(i_blankLeadingZero && suppressed);
  assign o_busy        = conv_busy;
  assign o_overflow    = overflow_q;

endmodule
